// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer.
// The WALK phase exists only when PED_WALK_EN is defined.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G,
    MAIN_Y,
    RED1,
    SIDE_G,
    SIDE_Y,
    RED2
`ifdef PED_WALK_EN
    ,
    WALK
`endif
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int D_MAIN_G = 8;
  localparam int D_SIDE_G = 5;
  localparam int D_YEL    = 3;
  localparam int D_RED    = 1;
  localparam int D_WALK   = 6;

  // The timer takes a 4-bit seconds value.
  function automatic bit dur_ok(input int t);
    return (t >= 1) && (t <= 15);
  endfunction

endpackage

// File: rtl/req_latch.sv
// Sticky request flag: set on demand, cleared when served.
// Clear dominates set so a request consumed on entry is not re-armed.
module req_latch (
  input  logic clk,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 1'b0;
    end else if (set_i) begin
      q_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer driving the one-second Timer block.
// Define PED_WALK_EN to add the pedestrian WALK phase and ports.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_MAIN_G = D_MAIN_G,
  parameter int T_SIDE_G = D_SIDE_G,
  parameter int T_YEL    = D_YEL,
  parameter int T_RED    = D_RED,
  parameter int T_WALK   = D_WALK
) (
  input  logic       clk,
  input  logic       Sync_Reset,
  input  logic       Expired,
  input  logic       Car_Side,
`ifdef PED_WALK_EN
  input  logic       Ped_Button,
  output logic       Walk,
`endif
  output logic       Start_Timer,
  output logic [3:0] Value,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light
);

  if (!(dur_ok(T_MAIN_G) && dur_ok(T_SIDE_G) &&
        dur_ok(T_YEL) && dur_ok(T_RED) &&
        dur_ok(T_WALK))) begin : g_bad_dur
    $error("traffic_phase_ctrl: durations must be 1..15");
  end

  state_e     state_q, state_d;
  logic       exp_q;
  logic       start_q;
  logic       pend_q;
  logic [3:0] value_q, value_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       advance;

  logic       side_set, side_clr;
  logic       side_lq, side_req;
  logic       any_req;

  // Edges seen while the start pulse is out predate the new phase.
  assign advance = Expired & ~exp_q & ~start_q;

  assign side_set = Car_Side & (state_q != SIDE_G);
  assign side_req = side_lq | side_set;
  assign side_clr = advance & (state_d == SIDE_G);

  req_latch u_side_req (
    .clk   (clk),
    .rst_i (Sync_Reset),
    .set_i (side_set),
    .clr_i (side_clr),
    .q_o   (side_lq)
  );

`ifdef PED_WALK_EN
  logic ped_set, ped_clr;
  logic ped_lq, ped_req;
  logic walk_q, walk_d;

  assign ped_set = Ped_Button & (state_q != WALK);
  assign ped_req = ped_lq | ped_set;
  assign ped_clr = advance & (state_d == WALK);

  req_latch u_ped_req (
    .clk   (clk),
    .rst_i (Sync_Reset),
    .set_i (ped_set),
    .clr_i (ped_clr),
    .q_o   (ped_lq)
  );

  assign any_req = side_req | ped_req;
  assign Walk    = walk_q;
`else
  assign any_req = side_req;
`endif

  always_comb begin
    state_d = state_q;
    if (advance) begin
      unique case (state_q)
        MAIN_G: state_d = any_req ? MAIN_Y : MAIN_G;
        MAIN_Y: state_d = RED1;
`ifdef PED_WALK_EN
        RED1:   state_d = side_req ? SIDE_G : WALK;
`else
        RED1:   state_d = SIDE_G;
`endif
        SIDE_G: state_d = SIDE_Y;
        SIDE_Y: state_d = RED2;
`ifdef PED_WALK_EN
        RED2:   state_d = ped_req ? WALK : MAIN_G;
        WALK:   state_d = RED2;
`else
        RED2:   state_d = MAIN_G;
`endif
        default: state_d = MAIN_G;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    main_d  = LAMP_R;
    side_d  = LAMP_R;
    value_d = 4'(T_RED);
`ifdef PED_WALK_EN
    walk_d  = 1'b0;
`endif
    unique case (state_d)
      MAIN_G: begin
        main_d  = LAMP_G;
        value_d = 4'(T_MAIN_G);
      end
      MAIN_Y: begin
        main_d  = LAMP_Y;
        value_d = 4'(T_YEL);
      end
      SIDE_G: begin
        side_d  = LAMP_G;
        value_d = 4'(T_SIDE_G);
      end
      SIDE_Y: begin
        side_d  = LAMP_Y;
        value_d = 4'(T_YEL);
      end
`ifdef PED_WALK_EN
      WALK: begin
        walk_d  = 1'b1;
        value_d = 4'(T_WALK);
      end
`endif
      default: value_d = 4'(T_RED);
    endcase
  end

  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      state_q <= MAIN_G;
      exp_q   <= 1'b0;
      start_q <= 1'b0;
      pend_q  <= 1'b1;
      value_q <= 4'(T_MAIN_G);
      main_q  <= LAMP_G;
      side_q  <= LAMP_R;
`ifdef PED_WALK_EN
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= Expired;
      start_q <= pend_q | advance;
      pend_q  <= 1'b0;
      value_q <= value_d;
      main_q  <= main_d;
      side_q  <= side_d;
`ifdef PED_WALK_EN
      walk_q  <= walk_d;
`endif
    end
  end

  assign Start_Timer = start_q;
  assign Value       = value_q;
  assign Main_Light  = main_q;
  assign Side_Light  = side_q;

endmodule
